multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control state machine for the multi-cycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences instructions through the fetch, decode, execute, memory and writeback steps. On every cycle it drives the datapath mux selects (IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource), the register write enables and the memory strobes. It sits between the IR opcode field, the shared instruction/data memory (through a ready handshake) and the datapath.

## Interface
Parameters:
- none. Encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  opcode, IR[31:26]; valid from ID onward
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp  out  2  ALU op: 00 = add, 01 = sub, 10 = use funct
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address
- illegal  out  1  one-cycle pulse in ID when the opcode is unsupported
- state  out  4  current state, for debug

## Operation
- Moore FSM. Outputs decode from state only; the exception is the strobes that are gated by mem_ready. Any output not listed for a state is 0.
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle where mem_ready=1. Go to ID on mem_ready; otherwise hold.
- ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00, which precomputes the branch target into ALUOut. Dispatch on op:
  - 100011 (lw) or 101011 (sw) → MA
  - 000000 (R-type) → RX
  - 000100 (beq) → BR
  - 000010 (j) → JP
  - 001000 (addi) → AX (only with MC_ADDI_EN)
  - any other opcode → pulse illegal, go to IF
- MA: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MR for lw, MW for sw.
- MR: MemRead=1, IorD=1. Go to WB on mem_ready; otherwise hold.
- WB: RegWrite=1, MemtoReg=1, RegDst=0. Go to IF.
- MW: MemWrite=1, IorD=1, held until mem_ready. Go to IF on mem_ready.
- RX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RW.
- RW: RegWrite=1, RegDst=1, MemtoReg=0. Go to IF.
- BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to IF.
- JP: PCWrite=1, PCSource=10. Go to IF.
- AX / AW (MC_ADDI_EN only):
  - AX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to AW.
  - AW: RegWrite=1, RegDst=0, MemtoReg=0. Go to IF.
- The op input is sampled only in ID. Changes to op in other states have no effect.

## Timing
- rst asserted: state=IF immediately (asynchronous). All outputs are forced to 0 while rst=1, including MemRead and state=0.
- First fetch strobes appear in the first cycle after rst deasserts.
- Latency with mem_ready tied 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each memory wait cycle adds one cycle. mem_ready is ignored in states without a memory access.
- IRWrite/PCWrite in IF rise in the same cycle as mem_ready (combinational gating). MemRead stays high through the whole wait.
- rst asserted mid-instruction aborts it. No partial RegWrite or MemWrite is issued after the rst edge.
- Unused state codes go to IF on the next edge.

## Configuration
- MC_ADDI_EN defined: states AX/AW exist and op 001000 executes addi in 4 cycles.
- MC_ADDI_EN undefined: op 001000 is illegal; it pulses illegal in ID and returns to IF.

## Structure
- Shared package mc_pkg holds:
  - state encoding constants: IF=0, ID=1, MA=2, MR=3, WB=4, MW=5, RX=6, RW=7, BR=8, JP=9, AX=10, AW=11
  - opcode constants
  - ALUOp, ALUSrcB and PCSource codes
- One natural sub-module: mc_out_decode, a combinational state→control-vector decoder. The top keeps the state register, the next-state logic and the mem_ready gating.

## Test plan
- Reset: rst=1 mid-MR → all outputs 0, state=0. rst=0 → MemRead=1, ALUSrcB=01 next cycle.
- lw, op=100011, mem_ready=1 → state sequence 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 in state 4 only.
- Fetch stall: mem_ready=0 for 3 cycles in IF → state stays 0 and IRWrite=PCWrite=0. Both go to 1 in the mem_ready cycle; ID follows.
- sw with mem_ready low for 2 cycles in MW → MemWrite=1, IorD=1 for 3 cycles, then state 0. RegWrite is never 1.
- beq and j: beq gives states 0,1,8 with PCWriteCond=1, ALUOp=01, PCSource=01. j gives states 0,1,9 with PCWrite=1, PCSource=10.
- op=001000: without MC_ADDI_EN → illegal=1 for one cycle in ID, then IF. With MC_ADDI_EN → states 10,11 and RegWrite=1, RegDst=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes,
// opcodes, mux-select codes and the packed control vector.
// Optional feature macro: MC_ADDI_EN (adds the addi execute/writeback states).
package mc_pkg;

   typedef enum logic [3:0] {
      S_IF = 4'd0,
      S_ID = 4'd1,
      S_MA = 4'd2,
      S_MR = 4'd3,
      S_WB = 4'd4,
      S_MW = 4'd5,
      S_RX = 4'd6,
      S_RW = 4'd7,
      S_BR = 4'd8,
      S_JP = 4'd9,
      S_AX = 4'd10,
      S_AW = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // True for opcodes the FSM knows how to execute.
   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MC_ADDI_EN
         OP_ADDI:                              op_legal = 1'b1;
`endif
         default:                              op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state -> control-vector decoder (pure Moore outputs).
// Fetch strobes IRWrite/PCWrite are emitted ungated; the top qualifies them
// with mem_ready. AX/AW decode only when MC_ADDI_EN is defined.
module mc_out_decode
   import mc_pkg::*;
(
   input  logic [3:0]        st,
   output logic [CTRL_W-1:0] cv
);

   ctrl_t c;

   // Per-state control settings; anything not set stays 0.
   always_comb begin
      c = '0;
      case (state_t'(st))
         S_IF: begin
            c.memread  = 1'b1;
            c.alusrcb  = SRCB_FOUR;
            c.aluop    = ALU_ADD;
            c.pcsource = PCS_ALU;
            c.irwrite  = 1'b1;
            c.pcwrite  = 1'b1;
         end
         S_ID: begin
            c.alusrcb = SRCB_IMMSH;
            c.aluop   = ALU_ADD;
         end
         S_MA: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         S_MR: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_WB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_MW: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_RX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_B;
            c.aluop   = ALU_FUNCT;
         end
         S_RW: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BR: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = SRCB_B;
            c.aluop       = ALU_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = PCS_ALUOUT;
         end
         S_JP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCS_JUMP;
         end
`ifdef MC_ADDI_EN
         S_AX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
         end
         S_AW: begin
            c.regwrite = 1'b1;
         end
`endif
         default: c = '0;
      endcase
   end

   assign cv = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Holds the state
// register, next-state logic and mem_ready gating of the fetch strobes.
// Optional feature macro: MC_ADDI_EN (op 001000 executes addi via AX/AW;
// otherwise it is reported as illegal).
module multicycle_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal,
   output logic [3:0] state
);

   state_t            st_q, st_d;
   logic              is_lw_q;   // lw vs sw, captured in ID so op may change later
   logic [CTRL_W-1:0] cv;
   ctrl_t             c;
   logic              in_if;

   mc_out_decode u_dec (
      .st (st_q),
      .cv (cv)
   );

   assign c     = ctrl_t'(cv);
   assign in_if = (st_q == S_IF);

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= S_IF;
      else     st_q <= st_d;
   end

   // Remember the load/store direction at dispatch time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               is_lw_q <= 1'b0;
      else if (st_q == S_ID) is_lw_q <= (op == OP_LW);
   end

   // Next-state sequencing; op is only consulted in ID.
   always_comb begin
      st_d = S_IF;
      case (st_q)
         S_IF: st_d = mem_ready ? S_ID : S_IF;
         S_ID: begin
            case (op)
               OP_LW, OP_SW: st_d = S_MA;
               OP_RTYPE:     st_d = S_RX;
               OP_BEQ:       st_d = S_BR;
               OP_J:         st_d = S_JP;
`ifdef MC_ADDI_EN
               OP_ADDI:      st_d = S_AX;
`endif
               default:      st_d = S_IF;
            endcase
         end
         S_MA: st_d = is_lw_q ? S_MR : S_MW;
         S_MR: st_d = mem_ready ? S_WB : S_MR;
         S_WB: st_d = S_IF;
         S_MW: st_d = mem_ready ? S_IF : S_MW;
         S_RX: st_d = S_RW;
         S_RW: st_d = S_IF;
         S_BR: st_d = S_IF;
         S_JP: st_d = S_IF;
`ifdef MC_ADDI_EN
         S_AX: st_d = S_AW;
         S_AW: st_d = S_IF;
`endif
         default: st_d = S_IF;
      endcase
   end

   // Everything is held at 0 while rst is high, including the fetch read.
   // IRWrite/PCWrite in IF follow mem_ready combinationally.
   assign PCWrite     = ~rst & c.pcwrite & (~in_if | mem_ready);
   assign IRWrite     = ~rst & c.irwrite & mem_ready;
   assign PCWriteCond = ~rst & c.pcwritecond;
   assign IorD        = ~rst & c.iord;
   assign MemRead     = ~rst & c.memread;
   assign MemWrite    = ~rst & c.memwrite;
   assign MemtoReg    = ~rst & c.memtoreg;
   assign RegDst      = ~rst & c.regdst;
   assign RegWrite    = ~rst & c.regwrite;
   assign ALUSrcA     = ~rst & c.alusrca;
   assign ALUSrcB     = rst ? 2'b00 : c.alusrcb;
   assign ALUOp       = rst ? 2'b00 : c.aluop;
   assign PCSource    = rst ? 2'b00 : c.pcsource;
   assign illegal     = ~rst & (st_q == S_ID) & ~op_legal(op);
   assign state       = rst ? 4'd0 : st_q;

endmodule
